// File: rtl/clockgen_ctl_pkg.sv
// Shared types and helpers for the MCS-4 two-phase clock generator.
package clockgen_ctl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  // Converts a time in ns to a whole number of sysclk cycles.
  function automatic int ns_to_cyc(input int ns, input int tcy);
    return ns / tcy;
  endfunction

endpackage

// File: rtl/clockgen_phase.sv
// One clock phase: sets level at START, clears it at END, with one-sysclk edge strobes.
module clockgen_phase #(
  parameter int CW    = 7,
  parameter int START = 9,
  parameter int END   = 29
) (
  input  logic          sysclk,
  input  logic          sysreset_n,
  input  logic [CW-1:0] clockdiv,
  input  logic          advance,
  output logic          level,
  output logic          rise,
  output logic          fall
);

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (advance && clockdiv == CW'(START)) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (advance && clockdiv == CW'(END)) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clockgen_ctl.sv
// MCS-4 two-phase clock generator with run/halt/single-step control.
module clockgen_ctl
  import clockgen_ctl_pkg::*;
#(
  parameter int SYSCLK_TCY   = 20,
  parameter int TPW          = 400,
  parameter int TD1          = 400,
  parameter int TD2          = 200,
  parameter int EXT_CLK_PROP = 0
) (
  input  logic sysclk,
  input  logic sysreset_n,
  input  logic run,
  input  logic step,
  output logic stopped,
  output logic clk1,
  output logic clk2,
  output logic clk1_ext,
  output logic clk2_ext,
  output logic clk1_rise,
  output logic clk1_fall,
  output logic clk2_rise,
  output logic clk2_fall
);

  localparam int TD2C = ns_to_cyc(TD2, SYSCLK_TCY);
  localparam int TD1C = ns_to_cyc(TD1, SYSCLK_TCY);
  localparam int TPWC = ns_to_cyc(TPW, SYSCLK_TCY);
  localparam int CMAX = (TD1 + TD2 + 2 * TPW) / SYSCLK_TCY - 1;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int P1S  = TD2C - 1;
  localparam int P1E  = P1S + TPWC;
  localparam int P2S  = P1E + TD1C;
  localparam int P2E  = P2S + TPWC;

  // The _ext phases run on the same counter, so they may not wrap below zero.
  if ((TPW % SYSCLK_TCY) != 0 || (TD1 % SYSCLK_TCY) != 0 || (TD2 % SYSCLK_TCY) != 0)
    $error("clockgen_ctl: timing parameters must be multiples of SYSCLK_TCY");
  if (TD2C < 1)
    $error("clockgen_ctl: TD2 must be at least one sysclk");
  if (EXT_CLK_PROP > P1S)
    $error("clockgen_ctl: EXT_CLK_PROP exceeds clk1 start position");

  state_t        state;
  logic [CW-1:0] clockdiv;
  logic          step_pending;
  logic          advance;

  assign advance = (state != HALT);

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      state        <= HALT;
      clockdiv     <= CW'(CMAX);
      step_pending <= 1'b0;
      stopped      <= 1'b1;
    end else begin
      case (state)
        HALT: begin
          if (run) begin
            state    <= RUN;
            clockdiv <= '0;
            stopped  <= 1'b0;
          end else if (step || step_pending) begin
            state        <= STEP;
            clockdiv     <= '0;
            step_pending <= 1'b0;
            stopped      <= 1'b0;
          end
        end
        default: begin
          if (clockdiv != CW'(CMAX)) begin
            clockdiv <= clockdiv + CW'(1);
            if (step) step_pending <= 1'b1;
          end else if (run) begin
            state    <= RUN;
            clockdiv <= '0;
            if (step) step_pending <= 1'b1;
          end else if (step || step_pending) begin
            state        <= STEP;
            clockdiv     <= '0;
            step_pending <= 1'b0;
          end else begin
            state   <= HALT;
            stopped <= 1'b1;
          end
        end
      endcase
    end
  end

  clockgen_phase #(.CW(CW), .START(P1S), .END(P1E)) u_clk1 (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .clockdiv(clockdiv), .advance(advance),
    .level(clk1), .rise(clk1_rise), .fall(clk1_fall)
  );

  clockgen_phase #(.CW(CW), .START(P2S), .END(P2E)) u_clk2 (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .clockdiv(clockdiv), .advance(advance),
    .level(clk2), .rise(clk2_rise), .fall(clk2_fall)
  );

  logic unused_ext1_rise, unused_ext1_fall, unused_ext2_rise, unused_ext2_fall;

  clockgen_phase #(.CW(CW), .START(P1S - EXT_CLK_PROP), .END(P1E - EXT_CLK_PROP)) u_clk1_ext (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .clockdiv(clockdiv), .advance(advance),
    .level(clk1_ext), .rise(unused_ext1_rise), .fall(unused_ext1_fall)
  );

  clockgen_phase #(.CW(CW), .START(P2S - EXT_CLK_PROP), .END(P2E - EXT_CLK_PROP)) u_clk2_ext (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .clockdiv(clockdiv), .advance(advance),
    .level(clk2_ext), .rise(unused_ext2_rise), .fall(unused_ext2_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{unused_ext1_rise, unused_ext1_fall, unused_ext2_rise, unused_ext2_fall};

endmodule

// File: tb/tb_clockgen_ctl.sv
// Directed bench for clockgen_ctl: default timing plus a copy with EXT_CLK_PROP=3.
module tb_clockgen_ctl;

  logic sysclk = 1'b0;
  logic sysreset_n, run, step;

  logic stopped, clk1, clk2, clk1_ext, clk2_ext, clk1_rise, clk1_fall, clk2_rise, clk2_fall;
  logic stopped3, clk1b, clk2b, clk1_ext3, clk2_ext3, clk1_rise3, clk1_fall3, clk2_rise3, clk2_fall3;

  int tests = 0;
  int failed = 0;

  always #10 sysclk = ~sysclk;

  clockgen_ctl dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .run(run), .step(step), .stopped(stopped),
    .clk1(clk1), .clk2(clk2), .clk1_ext(clk1_ext), .clk2_ext(clk2_ext),
    .clk1_rise(clk1_rise), .clk1_fall(clk1_fall), .clk2_rise(clk2_rise), .clk2_fall(clk2_fall)
  );

  clockgen_ctl #(.EXT_CLK_PROP(3)) dut3 (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .run(run), .step(step), .stopped(stopped3),
    .clk1(clk1b), .clk2(clk2b), .clk1_ext(clk1_ext3), .clk2_ext(clk2_ext3),
    .clk1_rise(clk1_rise3), .clk1_fall(clk1_fall3), .clk2_rise(clk2_rise3), .clk2_fall(clk2_fall3)
  );

  // Drives inputs for one sysclk edge and returns 1 time unit after it.
  task automatic applyStimulus(input logic r, input logic s, input logic rst_n);
    run        = r;
    step       = s;
    sysreset_n = rst_n;
    @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    int r1, f1, r2, f2, r1b, r1e, f2e, hi1, nrise, nstop, stopr, late, nlow, n1r, n2f;
    logic [7:0] outs;

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("reset_stopped", int'(stopped), 1);
    outs = {clk1, clk2, clk1_ext, clk2_ext, clk1_rise, clk1_fall, clk2_rise, clk2_fall};
    checkOutput("reset_outputs", int'(outs), 0);

    // Free run from reset release: edge 1 is the edge sampling run.
    r1 = -1; f1 = -1; r2 = -1; f2 = -1; r1b = -1; r1e = -1; f2e = -1;
    hi1 = 0; nrise = 0; nstop = 0;
    for (int e = 1; e <= 91; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (clk1_rise && r1 < 0) r1 = e;
      else if (clk1_rise && r1b < 0) r1b = e;
      if (clk1_fall && f1 < 0) f1 = e;
      if (clk2_rise && r2 < 0) r2 = e;
      if (clk2_fall && f2 < 0) f2 = e;
      if (clk1_ext3 && r1e < 0) r1e = e;
      if (clk2_ext3) f2e = e + 1;
      if (e <= 80 && clk1) hi1++;
      if (e <= 80 && clk1_rise) nrise++;
      if (stopped) nstop++;
    end
    checkOutput("clk1_rise_edge", r1, 11);
    checkOutput("clk1_fall_edge", f1, 31);
    checkOutput("clk2_rise_edge", r2, 51);
    checkOutput("clk2_fall_edge", f2, 71);
    checkOutput("period_next_clk1_rise", r1b, 81);
    checkOutput("clk1_high_width", hi1, 20);
    checkOutput("clk1_rise_strobe_count", nrise, 1);
    checkOutput("stopped_while_running", nstop, 0);
    checkOutput("clk1_ext_lead3_rise", r1e, 8);
    checkOutput("clk2_ext_lead3_fall", f2e, 68);

    // Run dropped after clockdiv reaches 20; the cycle must still complete.
    f2 = -1; stopr = -1; late = 0;
    for (int e = 92; e <= 641; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (clk2_fall && f2 < 0) f2 = e;
      if (stopped && stopr < 0) stopr = e;
      if (e > 141 && (clk1_rise || clk1_fall || clk2_rise || clk2_fall)) late++;
    end
    checkOutput("halt_clk2_fall_edge", f2, 141);
    checkOutput("halt_stopped_edge", stopr, 141);
    checkOutput("halt_no_edges", late, 0);
    checkOutput("halt_clocks_low", int'({clk1, clk2}), 0);

    // Single step while halted.
    nlow = 0; n1r = 0; n2f = 0;
    for (int j = 0; j < 200; j++) begin
      applyStimulus(1'b0, (j == 0), 1'b1);
      if (!stopped) nlow++;
      if (clk1_rise) n1r++;
      if (clk2_fall) n2f++;
    end
    checkOutput("step_stopped_low", nlow, 70);
    checkOutput("step_clk1_pulses", n1r, 1);
    checkOutput("step_clk2_pulses", n2f, 1);

    // Two extra pulses during a stepped cycle: one pending, one dropped.
    nlow = 0; n1r = 0;
    for (int j = 0; j < 300; j++) begin
      applyStimulus(1'b0, (j == 0 || j == 10 || j == 20), 1'b1);
      if (!stopped) nlow++;
      if (clk1_rise) n1r++;
    end
    checkOutput("step2_stopped_low", nlow, 140);
    checkOutput("step2_clk1_pulses", n1r, 2);

    // Run and step together while halted: one run cycle, step discarded.
    nlow = 0;
    for (int j = 0; j < 200; j++) begin
      applyStimulus((j == 0), (j == 0), 1'b1);
      if (!stopped) nlow++;
    end
    checkOutput("run_beats_step", nlow, 70);

    // Reset at clockdiv=40, just after clk1 fell.
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 40; j++) applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("pre_reset_clk1_low", int'(clk1), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("midreset_stopped", int'(stopped), 1);
    outs = {clk1, clk2, clk1_ext, clk2_ext, clk1_rise, clk1_fall, clk2_rise, clk2_fall};
    checkOutput("midreset_outputs", int'(outs), 0);
    checkOutput("midreset_clockdiv", int'(dut.clockdiv), 69);
    for (int j = 0; j < 5; j++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_halted", int'(stopped), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
